lock_actuator_sequencer: RTL and testbench

// Bus-side controller for the lock actuators: sequences register writes to the neopixel (0x00) and servo (0x04)

---
 rtl/lock_actuator_sequencer.sv | 178 +++++++++++++++++
 tb/tb_lock_actuator_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_actuator_sequencer.sv
// Lock actuator sequencer: turns unlock/deny pulses into timed servo and neopixel
// register writes on the shared peripheral write bus, yielding to CPU traffic.
module lock_actuator_sequencer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned DENY_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter logic [31:0] SERVO_OPEN  = 32'd2000,
  parameter logic [31:0] SERVO_LOCK  = 32'd1000,
  parameter logic [31:0] NP_OPEN     = 32'h00FF0000,
  parameter logic [31:0] NP_LOCK     = 32'h0000FF00,
  parameter logic [31:0] NP_DENY     = 32'h0000FFFF
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        unlock_req,
  input  logic        deny_req,
  input  logic        bus_idle,
  output logic        bus_write_en,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_write_data,
  output logic        busy,
  output logic        door_open
);

  localparam logic [3:0] S_INIT_SERVO = 4'd0;
  localparam logic [3:0] S_INIT_LED   = 4'd1;
  localparam logic [3:0] S_IDLE       = 4'd2;
  localparam logic [3:0] S_OPEN_SERVO = 4'd3;
  localparam logic [3:0] S_OPEN_LED   = 4'd4;
  localparam logic [3:0] S_HOLD       = 4'd5;
  localparam logic [3:0] S_LOCK_SERVO = 4'd6;
  localparam logic [3:0] S_LOCK_LED   = 4'd7;
  localparam logic [3:0] S_DENY_LED   = 4'd8;
  localparam logic [3:0] S_DENY_HOLD  = 4'd9;

  localparam logic [7:0] ADDR_NP    = 8'h00;
  localparam logic [7:0] ADDR_SERVO = 8'h04;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DENY_LOAD = CNT_W'(DENY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             wr_go;
  logic [7:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             door_nx;
  logic             can_write;

  // A strobe is never issued in the cycle right after another one, so the
  // registered strobe itself blocks the next write state for one cycle.
  assign can_write = bus_idle && !bus_write_en;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_go    = 1'b0;
    wr_addr  = ADDR_NP;
    wr_data  = '0;
    door_nx  = door_open;
    case (state)
      S_INIT_SERVO: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_SERVO;
          wr_data  = SERVO_LOCK;
          state_nx = S_INIT_LED;
        end
      end
      S_INIT_LED: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_NP;
          wr_data  = NP_LOCK;
          state_nx = S_IDLE;
        end
      end
      S_IDLE: begin
        if (deny_req) begin
          state_nx = S_DENY_LED;
        end else if (unlock_req) begin
          state_nx = S_OPEN_SERVO;
        end
      end
      S_OPEN_SERVO: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_SERVO;
          wr_data  = SERVO_OPEN;
          door_nx  = 1'b1;
          state_nx = S_OPEN_LED;
        end
      end
      S_OPEN_LED: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_NP;
          wr_data  = NP_OPEN;
          cnt_nx   = HOLD_LOAD;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        // A fresh unlock restarts the full hold window; deny is ignored here.
        if (unlock_req) begin
          cnt_nx = HOLD_LOAD;
        end else if (cnt == '0) begin
          state_nx = S_LOCK_SERVO;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_LOCK_SERVO: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_SERVO;
          wr_data  = SERVO_LOCK;
          door_nx  = 1'b0;
          state_nx = S_LOCK_LED;
        end
      end
      S_LOCK_LED: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_NP;
          wr_data  = NP_LOCK;
          state_nx = S_IDLE;
        end
      end
      S_DENY_LED: begin
        if (can_write) begin
          wr_go    = 1'b1;
          wr_addr  = ADDR_NP;
          wr_data  = NP_DENY;
          cnt_nx   = DENY_LOAD;
          state_nx = S_DENY_HOLD;
        end
      end
      S_DENY_HOLD: begin
        // Deny only recolours the LED, so the return path skips the servo.
        if (cnt == '0) begin
          state_nx = S_LOCK_LED;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = S_INIT_SERVO;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state          <= S_INIT_SERVO;
      cnt            <= '0;
      bus_write_en   <= 1'b0;
      bus_addr       <= '0;
      bus_write_data <= '0;
      busy           <= 1'b1;
      door_open      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bus_write_en <= wr_go;
      if (wr_go) begin
        bus_addr       <= wr_addr;
        bus_write_data <= wr_data;
      end
      busy      <= !((state_nx == S_IDLE) || (state_nx == S_HOLD));
      door_open <= door_nx;
    end
  end

endmodule

// File: tb/tb_lock_actuator_sequencer.sv
// Scoreboard bench for lock_actuator_sequencer: expected bus writes are queued as
// stimulus is applied and matched against each observed strobe.
module tb_lock_actuator_sequencer;

  localparam int HOLD = 10;
  localparam int DENY = 4;

  logic        PCLK;
  logic        PRESETN;
  logic        unlock_req;
  logic        deny_req;
  logic        bus_idle;
  logic        bus_write_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic        busy;
  logic        door_open;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  stb_cyc[$];
  int  cyc;
  int  n_assert;
  int  n_fail;
  bit  prev_we;

  lock_actuator_sequencer #(
    .HOLD_CYCLES(HOLD),
    .DENY_CYCLES(DENY),
    .CNT_W(32)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .unlock_req(unlock_req),
    .deny_req(deny_req),
    .bus_idle(bus_idle),
    .bus_write_en(bus_write_en),
    .bus_addr(bus_addr),
    .bus_write_data(bus_write_data),
    .busy(busy),
    .door_open(door_open)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe must match the head of the expected queue.
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      prev_we = 1'b0;
    end else begin
      if (bus_write_en === 1'b1) begin
        stb_cyc.push_back(cyc);
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe cyc=%0d got addr=%h data=%h, required no write", cyc, bus_addr, bus_write_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({bus_addr, bus_write_data} !== {e.addr, e.data}) begin
            n_fail++;
            $display("FAIL write_content cyc=%0d got addr=%h data=%h, required addr=%h data=%h", cyc, bus_addr, bus_write_data, e.addr, e.data);
          end
        end
        n_assert++;
        if (prev_we) begin
          n_fail++;
          $display("FAIL back_to_back_strobe cyc=%0d got two consecutive strobes, required a gap", cyc);
        end
      end
      prev_we = (bus_write_en === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d, required bench completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_open_close();
    push(8'h04, 32'd2000);
    push(8'h00, 32'h00FF0000);
    push(8'h04, 32'd1000);
    push(8'h00, 32'h0000FF00);
  endtask

  task automatic pulse(input logic u, input logic d);
    unlock_req = u;
    deny_req   = d;
    tick();
    unlock_req = 1'b0;
    deny_req   = 1'b0;
  endtask

  task automatic wait_q(input int left, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() <= left) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && busy === 1'b0 && bus_write_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    PRESETN = 1'b0;
    repeat (3) tick();
    n_assert++;
    if ({bus_write_en, bus_addr, bus_write_data, busy, door_open} !== {1'b0, 8'h00, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got we=%b addr=%h data=%h busy=%b door=%b, required 0 00 00000000 1 0", bus_write_en, bus_addr, bus_write_data, busy, door_open);
    end
    stb_cyc.delete();
    push(8'h04, 32'd1000);
    push(8'h00, 32'h0000FF00);
    PRESETN = 1'b1;
    drain(50, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL init_drain got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    n_assert++;
    if (stb_cyc.size() !== 2 || !((stb_cyc[1] - stb_cyc[0]) >= 2)) begin
      n_fail++;
      $display("FAIL init_strobes got count=%0d, required 2 on separate cycles", stb_cyc.size());
    end
    n_assert++;
    if (door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL init_door got %b, required 0", door_open);
    end
  endtask

  task automatic test_unlock();
    bit ok;
    stb_cyc.delete();
    push_open_close();
    pulse(1'b1, 1'b0);
    wait_q(2, 20, ok);
    n_assert++;
    if (!ok || door_open !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_open got ok=%b door=%b busy=%b, required 1 1 0", ok, door_open, busy);
    end
    // A deny during the hold window must be ignored.
    pulse(1'b0, 1'b1);
    drain(60, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL unlock_drain got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    n_assert++;
    if (stb_cyc.size() !== 4 || (stb_cyc[2] - stb_cyc[1]) !== HOLD + 1) begin
      n_fail++;
      $display("FAIL hold_length got count=%0d gap=%0d, required 4 %0d", stb_cyc.size(), (stb_cyc.size() >= 3) ? stb_cyc[2] - stb_cyc[1] : -1, HOLD + 1);
    end
    n_assert++;
    if (door_open !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_relock got door=%b busy=%b, required 0 0", door_open, busy);
    end
  endtask

  task automatic test_hold_extend();
    bit ok;
    int s;
    stb_cyc.delete();
    push_open_close();
    pulse(1'b1, 1'b0);
    wait_q(2, 20, ok);
    s = cyc;
    while (cyc < s + 6) tick();
    pulse(1'b1, 1'b0);
    while (cyc < s + 15) tick();
    n_assert++;
    if (door_open !== 1'b1 || stb_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL extend_still_open got door=%b strobes=%0d, required 1 2", door_open, stb_cyc.size());
    end
    drain(60, ok);
    n_assert++;
    if (!ok || stb_cyc.size() !== 4 || stb_cyc[2] !== s + 7 + HOLD + 1) begin
      n_fail++;
      $display("FAIL extend_relock got ok=%b count=%0d cyc=%0d, required 1 4 %0d", ok, stb_cyc.size(), (stb_cyc.size() >= 3) ? stb_cyc[2] : -1, s + 7 + HOLD + 1);
    end
  endtask

  task automatic test_deny_priority();
    bit ok;
    stb_cyc.delete();
    push(8'h00, 32'h0000FFFF);
    push(8'h00, 32'h0000FF00);
    pulse(1'b1, 1'b1);
    wait_q(1, 20, ok);
    // Unlock arriving during the deny hold is dropped.
    pulse(1'b1, 1'b0);
    drain(40, ok);
    repeat (6) tick();
    n_assert++;
    if (!ok || stb_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL deny_strobes got ok=%b count=%0d, required 1 2", ok, stb_cyc.size());
    end
    n_assert++;
    if (stb_cyc.size() >= 2 && (stb_cyc[1] - stb_cyc[0]) !== DENY + 1) begin
      n_fail++;
      $display("FAIL deny_length got gap=%0d, required %0d", stb_cyc[1] - stb_cyc[0], DENY + 1);
    end
    n_assert++;
    if (door_open !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL deny_end got door=%b busy=%b, required 0 0", door_open, busy);
    end
  endtask

  task automatic test_bus_stall();
    bit ok;
    int c;
    stb_cyc.delete();
    bus_idle = 1'b0;
    push_open_close();
    pulse(1'b1, 1'b0);
    repeat (5) tick();
    n_assert++;
    if (stb_cyc.size() !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_strobe got strobes=%0d busy=%b, required 0 1", stb_cyc.size(), busy);
    end
    bus_idle = 1'b1;
    c = cyc;
    tick();
    n_assert++;
    if (stb_cyc.size() !== 1 || stb_cyc[0] !== c + 1) begin
      n_fail++;
      $display("FAIL stall_release got strobes=%0d at cyc=%0d, required 1 at %0d", stb_cyc.size(), (stb_cyc.size() >= 1) ? stb_cyc[0] : -1, c + 1);
    end
    drain(60, ok);
    n_assert++;
    if (!ok || stb_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL stall_drain got ok=%b count=%0d, required 1 4", ok, stb_cyc.size());
    end
  endtask

  task automatic test_reset_in_hold();
    bit ok;
    stb_cyc.delete();
    push_open_close();
    pulse(1'b1, 1'b0);
    wait_q(2, 20, ok);
    repeat (3) tick();
    #2;
    PRESETN = 1'b0;
    #1;
    n_assert++;
    if ({bus_write_en, bus_addr, bus_write_data, busy, door_open} !== {1'b0, 8'h00, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset got we=%b addr=%h data=%h busy=%b door=%b, required 0 00 00000000 1 0", bus_write_en, bus_addr, bus_write_data, busy, door_open);
    end
    exp_q.delete();
    repeat (2) tick();
    stb_cyc.delete();
    push(8'h04, 32'd1000);
    push(8'h00, 32'h0000FF00);
    PRESETN = 1'b1;
    drain(50, ok);
    n_assert++;
    if (!ok || stb_cyc.size() !== 2 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit got ok=%b count=%0d door=%b, required 1 2 0", ok, stb_cyc.size(), door_open);
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    prev_we    = 1'b0;
    PRESETN    = 1'b0;
    unlock_req = 1'b0;
    deny_req   = 1'b0;
    bus_idle   = 1'b1;
    test_reset();
    test_unlock();
    test_hold_extend();
    test_deny_priority();
    test_bus_stall();
    test_reset_in_hold();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
